// File: rtl/pe_pkg.sv
// Shared constants for the PE operand feeder: default geometry, lane indices
// and a few IEEE-754 single-precision operands used by benches.
package pe_pkg;

  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefBufferWidth = 2;
  localparam int unsigned DefBufferSize  = 4;

  localparam int unsigned NumLanes = 3;
  localparam int unsigned LANE_W   = 0;
  localparam int unsigned LANE_I   = 1;
  localparam int unsigned LANE_O   = 2;

  localparam logic [31:0] FP_4    = 32'h4080_0000;
  localparam logic [31:0] FP_15   = 32'h4170_0000;
  localparam logic [31:0] FP_40   = 32'h4220_0000;
  localparam logic [31:0] FP_100  = 32'h42C8_0000;
  localparam logic [31:0] FP_200  = 32'h4348_0000;
  localparam logic [31:0] FP_1000 = 32'h447A_0000;

endpackage

// File: rtl/pe_feed_fifo.sv
// Synchronous FIFO holding operand triples; head is read straight out of the
// storage array so it is visible the cycle after the write edge.
module pe_feed_fifo #(
  parameter int unsigned Width       = 96,
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned BufferSize  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       din,
  output logic [Width-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [BufferWidth:0]   occupancy
);

  logic [Width-1:0]       mem [BufferSize];
  logic [BufferWidth-1:0] wr_ptr;
  logic [BufferWidth-1:0] rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (occupancy == (BufferWidth+1)'(BufferSize));
  assign empty   = (occupancy == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at BufferSize.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/pe_operand_feeder.sv
// Transmit side of the PE W/I/O valid/ready streams. Buffers host triples and
// presents the head entry on three lanes; a triple retires once every lane
// has been accepted (independently, or all together in lockstep mode).
module pe_operand_feeder
  import pe_pkg::*;
#(
  parameter int unsigned DataWidth   = DefDataWidth,
  parameter int unsigned BufferWidth = DefBufferWidth,
  parameter int unsigned BufferSize  = DefBufferSize,
  parameter int unsigned Lockstep    = 0,
  parameter int unsigned CountWidth  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Host_DataInValid,
  output logic                  Host_DataInRdy,
  input  logic [DataWidth-1:0]  Host_W,
  input  logic [DataWidth-1:0]  Host_I,
  input  logic [DataWidth-1:0]  Host_O,
  output logic [DataWidth-1:0]  W_DataOut,
  output logic                  W_DataOutValid,
  input  logic                  W_DataOutRdy,
  output logic [DataWidth-1:0]  I_DataOut,
  output logic                  I_DataOutValid,
  input  logic                  I_DataOutRdy,
  output logic [DataWidth-1:0]  O_DataOut,
  output logic                  O_DataOutValid,
  input  logic                  O_DataOutRdy,
  output logic [CountWidth-1:0] Issued_Count,
  output logic                  Busy
);

  logic [3*DataWidth-1:0] head;
  logic                   full;
  logic                   empty;
  logic [BufferWidth:0]   occupancy;
  logic [NumLanes-1:0]    rdy;
  logic [NumLanes-1:0]    sent;
  logic [NumLanes-1:0]    valid;
  logic [NumLanes-1:0]    fire;
  logic                   retire;
  logic                   push;

  assign rdy[LANE_W] = W_DataOutRdy;
  assign rdy[LANE_I] = I_DataOutRdy;
  assign rdy[LANE_O] = O_DataOutRdy;

  // Push is gated on occupancy only; a same-cycle retire does not free space.
  assign Host_DataInRdy = ~full;
  assign push           = Host_DataInValid & ~full;
  assign Busy           = (occupancy != '0);

  pe_feed_fifo #(
    .Width      (3 * DataWidth),
    .BufferWidth(BufferWidth),
    .BufferSize (BufferSize)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (retire),
    .din      ({Host_O, Host_I, Host_W}),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .occupancy(occupancy)
  );

  // Per-lane valid/fire and the retire decision for the head triple.
  always_comb begin
    valid  = '0;
    fire   = '0;
    retire = 1'b0;
    if (!empty) begin
      if (Lockstep != 0) begin
        valid = '1;
        if (&rdy) begin
          fire   = '1;
          retire = 1'b1;
        end
      end else begin
        valid  = ~sent;
        fire   = valid & rdy;
        retire = &(sent | fire);
      end
    end
  end

  // Remember which lanes already delivered the head; cleared when it retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent <= '0;
    end else if (retire) begin
      sent <= '0;
    end else if (Lockstep == 0) begin
      sent <= sent | fire;
    end
  end

  // Count fully retired triples, wrapping at 2**CountWidth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Issued_Count <= '0;
    end else if (retire) begin
      Issued_Count <= Issued_Count + 1'b1;
    end
  end

  assign W_DataOutValid = valid[LANE_W];
  assign I_DataOutValid = valid[LANE_I];
  assign O_DataOutValid = valid[LANE_O];
  assign W_DataOut = empty ? '0 : head[LANE_W*DataWidth +: DataWidth];
  assign I_DataOut = empty ? '0 : head[LANE_I*DataWidth +: DataWidth];
  assign O_DataOut = empty ? '0 : head[LANE_O*DataWidth +: DataWidth];

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: one independent-mode and one lockstep-mode
// instance share all inputs and are each compared against a queue-based model.
module tb_pe_operand_feeder;
  import pe_pkg::*;

  logic        clk;
  logic        rst;
  logic        host_valid;
  logic [31:0] host_w, host_i, host_o;
  logic        w_rdy, i_rdy, o_rdy;

  logic [31:0] w_out [2];
  logic [31:0] i_out [2];
  logic [31:0] o_out [2];
  logic        w_val [2];
  logic        i_val [2];
  logic        o_val [2];
  logic        h_rdy [2];
  logic        busy  [2];
  logic [15:0] cnt   [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued triples {O,I,W}, delivered lanes, retire count.
  logic [95:0] q0[$];
  logic [95:0] q1[$];
  logic [2:0]  sent_m [2];
  logic [15:0] cnt_m  [2];

  pe_operand_feeder #(.Lockstep(0)) dut_ind (
    .clk(clk), .rst(rst),
    .Host_DataInValid(host_valid), .Host_DataInRdy(h_rdy[0]),
    .Host_W(host_w), .Host_I(host_i), .Host_O(host_o),
    .W_DataOut(w_out[0]), .W_DataOutValid(w_val[0]), .W_DataOutRdy(w_rdy),
    .I_DataOut(i_out[0]), .I_DataOutValid(i_val[0]), .I_DataOutRdy(i_rdy),
    .O_DataOut(o_out[0]), .O_DataOutValid(o_val[0]), .O_DataOutRdy(o_rdy),
    .Issued_Count(cnt[0]), .Busy(busy[0])
  );

  pe_operand_feeder #(.Lockstep(1)) dut_lck (
    .clk(clk), .rst(rst),
    .Host_DataInValid(host_valid), .Host_DataInRdy(h_rdy[1]),
    .Host_W(host_w), .Host_I(host_i), .Host_O(host_o),
    .W_DataOut(w_out[1]), .W_DataOutValid(w_val[1]), .W_DataOutRdy(w_rdy),
    .I_DataOut(i_out[1]), .I_DataOutValid(i_val[1]), .I_DataOutRdy(i_rdy),
    .O_DataOut(o_out[1]), .O_DataOutValid(o_val[1]), .O_DataOutRdy(o_rdy),
    .Issued_Count(cnt[1]), .Busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int qsize(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [95:0] qhead(input int m);
    if (qsize(m) == 0) return '0;
    return (m == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int m, input logic [95:0] t);
    if (m == 0) q0.push_back(t); else q1.push_back(t);
  endtask

  task automatic qpop(input int m);
    if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    sent_m[0] = '0; sent_m[1] = '0;
    cnt_m[0]  = '0; cnt_m[1]  = '0;
  endtask

  // Which lanes are accepted this cycle ({retire, fire[O,I,W]}).
  function automatic logic [3:0] lane_fire(input bit nonempty, input logic [2:0] sent,
                                           input logic [2:0] r, input bit lock);
    logic [2:0] f;
    if (!nonempty) return 4'b0000;
    if (lock) return (&r) ? 4'b1111 : 4'b0000;
    f = ~sent & r;
    return {&(sent | f), f};
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int m = 0; m < 2; m++) begin
      bit          ne;
      logic [2:0]  ev;
      logic [95:0] hd;
      ne = (qsize(m) != 0);
      hd = qhead(m);
      ev = !ne ? 3'b000 : ((m == 1) ? 3'b111 : ~sent_m[m]);
      chk($sformatf("%s.m%0d.valid", tag, m), 96'({o_val[m], i_val[m], w_val[m]}), 96'(ev));
      chk($sformatf("%s.m%0d.data", tag, m), {o_out[m], i_out[m], w_out[m]}, hd);
      chk($sformatf("%s.m%0d.host_rdy", tag, m), 96'(h_rdy[m]), 96'(qsize(m) < 4));
      chk($sformatf("%s.m%0d.busy", tag, m), 96'(busy[m]), 96'(ne));
      chk($sformatf("%s.m%0d.count", tag, m), 96'(cnt[m]), 96'(cnt_m[m]));
    end
  endtask

  task automatic model_advance(input logic hv, input logic [95:0] t, input logic [2:0] r);
    for (int m = 0; m < 2; m++) begin
      bit         fullm;
      logic [3:0] rf;
      fullm = (qsize(m) >= 4);
      rf = lane_fire(qsize(m) != 0, sent_m[m], r, m == 1);
      if (rf[3]) begin
        qpop(m);
        sent_m[m] = '0;
        cnt_m[m]  = cnt_m[m] + 16'd1;
      end else begin
        sent_m[m] = sent_m[m] | rf[2:0];
      end
      if (hv && !fullm) qpush(m, t);
    end
  endtask

  // One clock: check current outputs, drive new inputs, advance model, cross the edge.
  task automatic step(input logic hv, input logic [95:0] t, input logic [2:0] r, input string tag);
    check_outputs(tag);
    host_valid = hv;
    {host_o, host_i, host_w} = t;
    {o_rdy, i_rdy, w_rdy} = r;
    model_advance(hv, t, r);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) step(1'b0, '0, 3'b111, "drain");
  endtask

  logic [95:0] trip_a, trip_b, trip_c, trip_r;

  initial begin
    trip_a = {FP_40, FP_4, FP_15};
    trip_b = {FP_1000, FP_200, FP_100};
    trip_c = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    rst = 1'b1;
    host_valid = 1'b0;
    {host_o, host_i, host_w} = '0;
    {o_rdy, i_rdy, w_rdy} = 3'b000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single triple with all lanes ready: presented next cycle, retired the edge after.
    step(1'b1, trip_a, 3'b111, "push_a");
    chk("first.w", 96'(w_out[0]), 96'(FP_15));
    chk("first.i", 96'(i_out[0]), 96'(FP_4));
    chk("first.o", 96'(o_out[0]), 96'(FP_40));
    step(1'b0, '0, 3'b111, "present_a");
    step(1'b0, '0, 3'b111, "after_a");
    chk("first.count", 96'(cnt[0]), 96'd1);
    chk("first.busy", 96'(busy[0]), 96'd0);

    // Fill to capacity with every lane stalled; the fifth offer is refused.
    for (int k = 0; k < 4; k++) step(1'b1, {32'(k), 32'(k + 10), 32'(k + 20)}, 3'b000, "fill");
    chk("full.host_rdy", 96'(h_rdy[0]), 96'd0);
    step(1'b1, trip_c, 3'b000, "push5");
    // Retire and push on the same edge while full: push refused, occupancy drops to 3.
    step(1'b1, trip_c, 3'b111, "full_retire_push");
    chk("after_full_retire.host_rdy", 96'(h_rdy[0]), 96'd1);
    step(1'b1, trip_c, 3'b000, "push_after_full");
    drain();

    // Independent lanes: W and O go first, I later; then the next head appears.
    step(1'b1, trip_a, 3'b000, "ind_push_a");
    step(1'b1, trip_b, 3'b000, "ind_push_b");
    step(1'b0, '0, 3'b101, "ind_wo_fire");
    chk("ind.w_dropped", 96'(w_val[0]), 96'd0);
    chk("ind.i_held", 96'(i_val[0]), 96'd1);
    step(1'b0, '0, 3'b101, "ind_i_stall");
    step(1'b0, '0, 3'b111, "ind_i_fire");
    chk("ind.next_head", {o_out[0], i_out[0], w_out[0]}, trip_b);
    drain();

    // Lockstep: O stalled holds everything; releasing it fires all lanes together.
    step(1'b1, trip_a, 3'b000, "lck_push");
    step(1'b0, '0, 3'b011, "lck_o_stall");
    step(1'b0, '0, 3'b011, "lck_o_stall2");
    chk("lck.valids_held", 96'({o_val[1], i_val[1], w_val[1]}), 96'd7);
    step(1'b0, '0, 3'b111, "lck_fire");
    drain();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      trip_r = {$urandom, $urandom, $urandom};
      step(($urandom_range(0, 3) != 0), trip_r, 3'($urandom), "rand");
    end

    // Reset mid-transfer with W already delivered on the independent instance.
    drain();
    step(1'b1, trip_a, 3'b000, "mid_push_a");
    step(1'b1, trip_b, 3'b001, "mid_w_fire");
    step(1'b0, '0, 3'b000, "mid_partial");
    rst = 1'b1;
    host_valid = 1'b0;
    {o_rdy, i_rdy, w_rdy} = 3'b000;
    #1;
    model_reset();
    chk("rst.valids_ind", 96'({o_val[0], i_val[0], w_val[0]}), 96'd0);
    chk("rst.valids_lck", 96'({o_val[1], i_val[1], w_val[1]}), 96'd0);
    chk("rst.count", 96'(cnt[0]), 96'd0);
    check_outputs("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, trip_c, 3'b000, "post_rst_push");
    chk("post_rst.valids", 96'({o_val[0], i_val[0], w_val[0]}), 96'd7);
    chk("post_rst.data", {o_out[0], i_out[0], w_out[0]}, trip_c);
    step(1'b0, '0, 3'b111, "post_rst_fire");
    check_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
